// File: rtl/if_fetch_buf.sv
// ============================================================================
// if_fetch_buf : instruction fetch stage with a single-outstanding bus read
//                and a small instruction FIFO toward IF/ID.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module if_fetch_buf #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump_flag_i,
  input  logic [2:0]  hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic        fetch_hold_o
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_CNT1   = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR1 = AW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_pend_addr;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_addr [DEPTH];

  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_valid;

  // Reset gates the request so the bus sees no request while rst is low.
  assign w_req   = rst && (r_state == S_IDLE) && (r_count < C_FULL) && !jump_flag_i;
  assign w_valid = (r_count != '0);
  assign w_push  = (r_state == S_WAIT) && ibus_rvalid_i && !jump_flag_i;
  assign w_pop   = w_valid && (hold_flag_i == 3'b000) && !jump_flag_i;

  assign ibus_req_o   = w_req;
  assign ibus_addr_o  = pc_i;
  assign fetch_hold_o = !(w_req && ibus_gnt_i);
  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? r_data[r_rd_ptr] : NOP_INST;
  assign inst_addr_o  = w_valid ? r_addr[r_rd_ptr] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pend_addr <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && ibus_gnt_i) begin
            r_state     <= S_WAIT;
            r_pend_addr <= pc_i;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i)    r_state <= S_IDLE;
          else if (jump_flag_i) r_state <= S_DROP;
        end
        S_DROP: begin
          if (ibus_rvalid_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A jump flushes the queue and wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (jump_flag_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT1;
        2'b01:   r_count <= r_count - C_CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= ibus_rdata_i;
      r_addr[r_wr_ptr] <= r_pend_addr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_buf.sv
// ============================================================================
// tb_if_fetch_buf : directed self-checking bench for if_fetch_buf (DEPTH=2).
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_buf;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_flag_i;
  logic [2:0]  hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        fetch_hold_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  if_fetch_buf #(.DEPTH(2), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .jump_flag_i  (jump_flag_i),
    .hold_flag_i  (hold_flag_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .fetch_hold_o (fetch_hold_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; pc_i = 32'h0; jump_flag_i = 1'b0; hold_flag_i = 3'b000;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;

    // reset values
    #3;
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst",  inst_o, NOP);
    chk("rst_iaddr", inst_addr_o, 32'h0);
    chk("rst_req",   {31'b0, ibus_req_o}, 32'd0);
    chk("rst_fhold", {31'b0, fetch_hold_o}, 32'd1);
    step();
    rst = 1'b1;

    // basic fetch: gnt immediately, rvalid one cycle later
    pc_i = 32'h0; ibus_gnt_i = 1'b1;
    #2;
    chk("b_req",   {31'b0, ibus_req_o}, 32'd1);
    chk("b_fhold", {31'b0, fetch_hold_o}, 32'd0);
    chk("b_addr",  ibus_addr_o, 32'h0);
    step();
    pc_i = 32'h4; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h00500093;
    #2;
    chk("b_req_wait", {31'b0, ibus_req_o}, 32'd0);
    chk("b_fhold_w",  {31'b0, fetch_hold_o}, 32'd1);
    chk("b_valid0",   {31'b0, inst_valid_o}, 32'd0);
    step();
    ibus_rvalid_i = 1'b0;
    #2;
    chk("b_valid1", {31'b0, inst_valid_o}, 32'd1);
    chk("b_inst",   inst_o, 32'h00500093);
    chk("b_iaddr",  inst_addr_o, 32'h0);
    chk("b_fhold2", {31'b0, fetch_hold_o}, 32'd1);
    step();
    #2;
    chk("b_popped", {31'b0, inst_valid_o}, 32'd0);
    chk("b_nop",    inst_o, NOP);

    // grant withheld for three cycles
    pc_i = 32'h8; ibus_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("g_req",   {31'b0, ibus_req_o}, 32'd1);
      chk("g_addr",  ibus_addr_o, 32'h8);
      chk("g_fhold", {31'b0, fetch_hold_o}, 32'd1);
      step();
      #2;
    end
    ibus_gnt_i = 1'b1;
    #1;
    chk("g_fhold_gnt", {31'b0, fetch_hold_o}, 32'd0);
    step();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hAAAA0001; pc_i = 32'hC;
    step();
    ibus_rvalid_i = 1'b0;
    #2;
    chk("g_iaddr", inst_addr_o, 32'h8);
    chk("g_inst",  inst_o, 32'hAAAA0001);
    step();

    // consumer stalled: fill both entries, then drain in order
    hold_flag_i = 3'b010; pc_i = 32'h0; ibus_gnt_i = 1'b1;
    step();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h11111111; pc_i = 32'h4;
    step();
    ibus_rvalid_i = 1'b0; ibus_gnt_i = 1'b1;
    #2;
    chk("h_valid1", {31'b0, inst_valid_o}, 32'd1);
    chk("h_req1",   {31'b0, ibus_req_o}, 32'd1);
    step();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h22222222; pc_i = 32'h8;
    step();
    ibus_rvalid_i = 1'b0;
    #2;
    chk("h_req_full", {31'b0, ibus_req_o}, 32'd0);
    chk("h_head_a",   inst_addr_o, 32'h0);
    chk("h_head_d",   inst_o, 32'h11111111);
    step();
    hold_flag_i = 3'b000;
    #2;
    chk("h_still_a", inst_addr_o, 32'h0);
    step();
    #2;
    chk("h_pop2_a", inst_addr_o, 32'h4);
    chk("h_pop2_d", inst_o, 32'h22222222);
    chk("h_req_rs", {31'b0, ibus_req_o}, 32'd1);
    step();
    #2;
    chk("h_empty", {31'b0, inst_valid_o}, 32'd0);

    // jump while waiting for data
    pc_i = 32'h20; ibus_gnt_i = 1'b1;
    step();
    ibus_gnt_i = 1'b0; jump_flag_i = 1'b1;
    #2;
    chk("j_req_jmp", {31'b0, ibus_req_o}, 32'd0);
    step();
    jump_flag_i = 1'b0; pc_i = 32'h100;
    #2;
    chk("j_req_drop", {31'b0, ibus_req_o}, 32'd0);
    step();
    ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hDEADBEEF;
    step();
    ibus_rvalid_i = 1'b0;
    #2;
    chk("j_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("j_nop",   inst_o, NOP);
    chk("j_req",   {31'b0, ibus_req_o}, 32'd1);
    chk("j_addr",  ibus_addr_o, 32'h100);
    ibus_gnt_i = 1'b1;
    step();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h33333333; pc_i = 32'h104;
    step();
    ibus_rvalid_i = 1'b0;
    #2;
    chk("j_new_a", inst_addr_o, 32'h100);
    chk("j_new_d", inst_o, 32'h33333333);
    step();

    // jump coincident with rvalid and a pop-eligible head
    hold_flag_i = 3'b010; pc_i = 32'h40; ibus_gnt_i = 1'b1;
    step();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h44444444; pc_i = 32'h44;
    step();
    ibus_rvalid_i = 1'b0; ibus_gnt_i = 1'b1;
    step();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h55555555;
    jump_flag_i = 1'b1; hold_flag_i = 3'b000;
    #2;
    chk("c_head_a", inst_addr_o, 32'h40);
    step();
    ibus_rvalid_i = 1'b0; jump_flag_i = 1'b0; hold_flag_i = 3'b010;
    #2;
    chk("c_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("c_nop",   inst_o, NOP);
    chk("c_iaddr", inst_addr_o, 32'h0);
    chk("c_idle",  {31'b0, ibus_req_o}, 32'd1);
    step();
    #2;
    chk("c_nostale", {31'b0, inst_valid_o}, 32'd0);

    // asynchronous reset in the middle of a read
    pc_i = 32'h60; ibus_gnt_i = 1'b1;
    step();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h66666666; pc_i = 32'h64;
    step();
    ibus_rvalid_i = 1'b0; ibus_gnt_i = 1'b1;
    step();
    ibus_gnt_i = 1'b0;
    #2;
    chk("r_pre_valid", {31'b0, inst_valid_o}, 32'd1);
    chk("r_pre_inst",  inst_o, 32'h66666666);
    rst = 1'b0;
    #1;
    chk("r_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("r_inst",  inst_o, NOP);
    chk("r_iaddr", inst_addr_o, 32'h0);
    chk("r_req",   {31'b0, ibus_req_o}, 32'd0);
    chk("r_fhold", {31'b0, fetch_hold_o}, 32'd1);
    step();
    rst = 1'b1; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h77777777;
    step();
    ibus_rvalid_i = 1'b0;
    #2;
    chk("r_late_ign", {31'b0, inst_valid_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_buf.md
Name: if_fetch_buf

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Takes the current fetch PC and issues one instruction-bus read at a time. Buffers returned words in a small FIFO and presents them with their addresses to the IF/ID stage.
- Back-pressures the PC register through a hold request until the current PC has been granted.
- Flushes on jump.

Parameters:
- DEPTH, 2: instruction FIFO entries; power of two, 2..8.
- NOP_INST, 32'h00000013: value driven on inst_o when no valid instruction is available (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_i  in  32  fetch address from the PC register.
- jump_flag_i  in  1  redirect from execute; flush all fetch state.
- hold_flag_i  in  3  pipeline hold from the control unit; any value >= 3'b001 stalls the IF/ID consumer.
- ibus_req_o  out  1  instruction bus read request.
- ibus_addr_o  out  32  request address (= pc_i).
- ibus_gnt_i  in  1  bus accepted the request this cycle.
- ibus_rvalid_i  in  1  read data valid.
- ibus_rdata_i  in  32  read data.
- inst_o  out  32  head instruction.
- inst_addr_o  out  32  address of the head instruction.
- inst_valid_o  out  1  FIFO non-empty.
- fetch_hold_o  out  1  request to the PC register to hold pc_i.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; FIFO empty (count=0, pointers 0); pending_addr=0.
  - Outputs: inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, ibus_req_o=0, fetch_hold_o=1.
  - Reset asserted mid-transaction abandons it. Any late rvalid after reset release is ignored unless in WAIT_DATA (i.e. none, since state is IDLE).
- States:
  - IDLE: no outstanding read.
  - WAIT_DATA: one read granted, data pending.
  - DROP: one read granted, data to be discarded.
- Request (combinational): ibus_req_o = (state==IDLE) & (count<DEPTH) & ~jump_flag_i. ibus_addr_o=pc_i always.
- IDLE -> WAIT_DATA on ibus_req_o & ibus_gnt_i; latch pending_addr<=pc_i.
  - While the request is ungranted, req stays high and pc_i is stable because fetch_hold_o=1.
- fetch_hold_o = ~(ibus_req_o & ibus_gnt_i): the PC advances only in the grant cycle. Jump priority in the PC register overrides the hold.
- WAIT_DATA:
  - On ibus_rvalid_i with no jump: push {pending_addr, ibus_rdata_i}, go to IDLE.
  - On ibus_rvalid_i & jump_flag_i: discard the data, go to IDLE.
  - On jump_flag_i without rvalid: go to DROP.
- DROP:
  - On ibus_rvalid_i: discard, go to IDLE.
  - A jump while in DROP has no further effect.
- Single outstanding transaction only. A new request is never issued in the same cycle as rvalid; the earliest is the next cycle.
- Pop: when inst_valid_o & (hold_flag_i==3'b000) & ~jump_flag_i, advance the read pointer.
- Push and pop in the same cycle: count unchanged.
- Push into a full FIFO cannot occur, because a request is issued only when count<DEPTH and count cannot grow before the response.
- Flush: jump_flag_i clears the FIFO (count=0, pointers 0) in the same edge. Flush takes priority over push and pop.
- Outputs:
  - inst_valid_o = (count!=0).
  - When valid: inst_o and inst_addr_o come from the head entry.
  - When not valid: inst_o=NOP_INST, inst_addr_o=0.
- Latency: gnt at cycle t, rvalid at t+k (k>=1); the instruction is visible on inst_valid_o at t+k+1.
- Pointer arithmetic: log2(DEPTH) bits, wrapping modulo DEPTH. count is log2(DEPTH)+1 bits.

Test Plan:
- Reset, then pc_i=0, gnt=1, rvalid one cycle after gnt with data 32'h00500093 -> req at cycle 1; inst_valid_o=1, inst_o=32'h00500093, inst_addr_o=0 two cycles after gnt; fetch_hold_o low only in grant cycles.
- Hold gnt low for 3 cycles -> req stays 1, ibus_addr_o constant, fetch_hold_o=1 throughout; grant on cycle 4 latches the same address.
- hold_flag_i=3'b010 while fetching 0x0,0x4 with DEPTH=2 -> FIFO fills to 2, req drops, head stays addr 0. Release hold -> pops 0x0 then 0x4 in order; req resumes.
- jump_flag_i in WAIT_DATA, rvalid two cycles later with 32'hDEADBEEF -> data discarded, FIFO empty, inst_o=NOP_INST; next request uses the new pc_i (e.g. 0x100).
- jump_flag_i coincident with rvalid and with a pop of a 2-entry FIFO -> FIFO empty next cycle, state IDLE, no stale entry emitted.
- Assert rst asynchronously mid-WAIT_DATA -> outputs return to reset values immediately without waiting for a clk edge.
